// File: rtl/rv32i_types.sv
// Shared types for the RV32I core pipeline control.
// The hazard_ctrl state is a direct encoding of {ireq_out, dreq_out}.
package rv32i_types;

   typedef enum logic [1:0] {
      RUN    = 2'b00,
      DWAIT  = 2'b01,
      IWAIT  = 2'b10,
      IDWAIT = 2'b11
   } hazard_state_t;

   localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle.
// master: the datapath (drives hazard sources, consumes controls).
// slave : hazard_ctrl.
interface hazard_ctrl_if;
   import rv32i_types::*;

   // hazard sources
   logic [4:0]    ID_rs1;
   logic [4:0]    ID_rs2;
   logic          ID_uses_rs1;
   logic          ID_uses_rs2;
   logic          EX_is_load;
   logic [4:0]    EX_rd;
   logic          EX_redirect;
   logic [31:0]   EX_target_pc;
   logic          imem_read;
   logic          imem_resp;
   logic          dmem_access;
   logic          dmem_resp;

   // pipeline controls
   logic          stall_if;
   logic          stall_id;
   logic          stall_ex;
   logic          stall_mem;
   logic          flush_id;
   logic          bubble_ex;
   logic          bubble_wb;
   logic          fetch_pc_load;
   logic [31:0]   fetch_pc_target;

   // event counters
   logic [31:0]   perf_loaduse;
   logic [31:0]   perf_istall;
   logic [31:0]   perf_dstall;
   logic [31:0]   perf_flush;

   // status, for debug visibility
   hazard_state_t st;
   logic          pend_v;

   modport master (
      output ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2, EX_is_load, EX_rd,
             EX_redirect, EX_target_pc, imem_read, imem_resp, dmem_access, dmem_resp,
      input  stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex, bubble_wb,
             fetch_pc_load, fetch_pc_target,
             perf_loaduse, perf_istall, perf_dstall, perf_flush, st, pend_v
   );

   modport slave (
      input  ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2, EX_is_load, EX_rd,
             EX_redirect, EX_target_pc, imem_read, imem_resp, dmem_access, dmem_resp,
      output stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex, bubble_wb,
             fetch_pc_load, fetch_pc_target,
             perf_loaduse, perf_istall, perf_dstall, perf_flush, st, pend_v
   );

endinterface

// File: rtl/sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
// ld gives a synchronous preload (takes priority over en).
module sat_counter32 (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        ld,
   input  logic [31:0] ld_val,
   output logic [31:0] cnt
);

   logic [31:0] cnt_q, cnt_d;

   // next count: preload, else increment unless saturated
   always_comb begin
      cnt_d = cnt_q;
      if (ld)
         cnt_d = ld_val;
      else if (en && (cnt_q != 32'hFFFF_FFFF))
         cnt_d = cnt_q + 32'd1;
   end

   // count register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage RV32I hazard / stall controller.
// Priority: D-stall > redirect > pending-redirect resolve > load-use > I-stall.
// HAZARD_CTRL_PERF_EN compiles in the four saturating perf counters;
// without it the perf_* outputs are tied to zero.
module hazard_ctrl
   import rv32i_types::*;
(
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.slave hz
);

   hazard_state_t st_q, st_d;
   logic          pend_v_q, pend_v_d;
   logic [31:0]   pend_pc_q, pend_pc_d;

   logic ireq_out, dreq_out, load_use;
   logic ev_loaduse, ev_istall, ev_dstall, ev_flush;

   assign ireq_out = hz.imem_read & ~hz.imem_resp;
   assign dreq_out = hz.dmem_access & ~hz.dmem_resp;

   // x0 is never a real producer, so it cannot cause a load-use stall
   assign load_use = hz.EX_is_load && (hz.EX_rd != REG_X0) &&
                     ((hz.ID_uses_rs1 && (hz.ID_rs1 == hz.EX_rd)) ||
                      (hz.ID_uses_rs2 && (hz.ID_rs2 == hz.EX_rd)));

   // stage controls and pending-redirect next state, in priority order
   always_comb begin
      hz.stall_if        = 1'b0;
      hz.stall_id        = 1'b0;
      hz.stall_ex        = 1'b0;
      hz.stall_mem       = 1'b0;
      hz.flush_id        = 1'b0;
      hz.bubble_ex       = 1'b0;
      hz.bubble_wb       = 1'b0;
      hz.fetch_pc_load   = 1'b0;
      hz.fetch_pc_target = '0;
      st_d               = hazard_state_t'({ireq_out, dreq_out});
      pend_v_d           = pend_v_q;
      pend_pc_d          = pend_pc_q;
      ev_loaduse         = 1'b0;
      ev_istall          = 1'b0;
      ev_dstall          = 1'b0;
      ev_flush           = 1'b0;
      if (rst) begin
         if (dreq_out) begin
            // EX cannot advance: redirect, load-use and pending work wait
            hz.stall_if  = 1'b1;
            hz.stall_id  = 1'b1;
            hz.stall_ex  = 1'b1;
            hz.stall_mem = 1'b1;
            hz.bubble_wb = 1'b1;
            ev_dstall    = 1'b1;
         end else if (hz.EX_redirect) begin
            hz.flush_id  = 1'b1;
            hz.bubble_ex = 1'b1;
            ev_flush     = 1'b1;
            if (ireq_out) begin
               // fetch in flight: park the target, youngest redirect wins
               hz.stall_if = 1'b1;
               pend_v_d    = 1'b1;
               pend_pc_d   = hz.EX_target_pc;
               ev_istall   = 1'b1;
            end else begin
               // applied directly; any older parked target is obsolete
               hz.fetch_pc_load   = 1'b1;
               hz.fetch_pc_target = hz.EX_target_pc;
               pend_v_d           = 1'b0;
            end
         end else if (pend_v_q && hz.imem_resp) begin
            // wrong-path word returns: drop it and steer fetch to the parked PC.
            // ID only holds NOPs while a redirect is parked, so this outranks load-use.
            hz.flush_id        = 1'b1;
            hz.fetch_pc_load   = 1'b1;
            hz.fetch_pc_target = pend_pc_q;
            pend_v_d           = 1'b0;
         end else if (load_use) begin
            hz.stall_if  = 1'b1;
            hz.stall_id  = 1'b1;
            hz.bubble_ex = 1'b1;
            ev_loaduse   = 1'b1;
         end else if (ireq_out) begin
            // IF holds, downstream drains behind NOPs
            hz.stall_if = 1'b1;
            hz.flush_id = 1'b1;
            ev_istall   = 1'b1;
         end
      end
   end

   // state and pending-redirect buffer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q      <= RUN;
         pend_v_q  <= 1'b0;
         pend_pc_q <= '0;
      end else begin
         st_q      <= st_d;
         pend_v_q  <= pend_v_d;
         pend_pc_q <= pend_pc_d;
      end
   end

   assign hz.st     = st_q;
   assign hz.pend_v = pend_v_q;

`ifdef HAZARD_CTRL_PERF_EN
   sat_counter32 u_cnt_loaduse (
      .clk(clk), .rst(rst), .en(ev_loaduse), .ld(1'b0), .ld_val(32'd0), .cnt(hz.perf_loaduse));
   sat_counter32 u_cnt_istall (
      .clk(clk), .rst(rst), .en(ev_istall), .ld(1'b0), .ld_val(32'd0), .cnt(hz.perf_istall));
   sat_counter32 u_cnt_dstall (
      .clk(clk), .rst(rst), .en(ev_dstall), .ld(1'b0), .ld_val(32'd0), .cnt(hz.perf_dstall));
   sat_counter32 u_cnt_flush (
      .clk(clk), .rst(rst), .en(ev_flush), .ld(1'b0), .ld_val(32'd0), .cnt(hz.perf_flush));
`else
   logic unused_ev;
   assign unused_ev       = ^{ev_loaduse, ev_istall, ev_dstall, ev_flush};
   assign hz.perf_loaduse = '0;
   assign hz.perf_istall  = '0;
   assign hz.perf_dstall  = '0;
   assign hz.perf_flush   = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage RV32I core. It sequences the IF/ID/EX/MEM/WB pipeline registers. It turns load-use dependences, instruction/data memory waits and EX-stage control-flow redirects into per-stage stall, bubble and flush controls. It owns the single-entry pending-redirect buffer used when a redirect arrives while an instruction fetch is still outstanding.

## Interface
Parameters:
- none

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- ID_rs1, ID_rs2  in  5  source registers of the instruction in ID
- ID_uses_rs1, ID_uses_rs2  in  1  ID instruction reads rs1/rs2
- EX_is_load  in  1  instruction in EX is a load
- EX_rd  in  5  destination of the instruction in EX
- EX_redirect  in  1  EX resolved a taken branch, jal or jalr that differs from the fetched path
- EX_target_pc  in  32  redirect target from EX
- imem_read, imem_resp  in  1  instruction-side request / completion
- dmem_access, dmem_resp  in  1  data-side request (read or write) / completion
- stall_if, stall_id, stall_ex, stall_mem  out  1  hold the stage's pipeline register
- flush_id  out  1  IF/ID loads a NOP
- bubble_ex  out  1  ID/EX loads a NOP
- bubble_wb  out  1  MEM/WB loads a NOP
- fetch_pc_load  out  1  fetch PC takes fetch_pc_target this cycle
- fetch_pc_target  out  32  redirect PC
- perf_loaduse, perf_istall, perf_dstall, perf_flush  out  32  event counters (see Configuration)

## Operation
- State register `st`: RUN, IWAIT, DWAIT, IDWAIT.
- Each cycle, `ireq_out = imem_read & ~imem_resp` and `dreq_out = dmem_access & ~dmem_resp`.
- The next state encodes {ireq_out, dreq_out}: 00→RUN, 10→IWAIT, 01→DWAIT, 11→IDWAIT.
- Stall and flush outputs are combinational from the current inputs, evaluated in the priority order below.

Priority order:
1. **D-stall** (`dreq_out`): assert stall_if, stall_id, stall_ex, stall_mem and bubble_wb. EX_redirect and load-use are ignored this cycle because the EX instruction does not advance.
2. **Redirect** (EX_redirect and not D-stalled): assert flush_id and bubble_ex.
   - If `ireq_out` is 0: fetch_pc_load=1, fetch_pc_target=EX_target_pc.
   - If `ireq_out` is 1: latch the target into `pend_pc`, set `pend_v`, and assert stall_if.
3. **Load-use**: EX_is_load, EX_rd≠0, and ((ID_uses_rs1 & ID_rs1==EX_rd) | (ID_uses_rs2 & ID_rs2==EX_rd)), with no D-stall and no redirect. Assert stall_if, stall_id and bubble_ex.
4. **I-stall** (`ireq_out` only): assert stall_if and flush_id. Downstream stages drain.

Pending redirect:
- While `pend_v` is set and `imem_resp` rises, the returned wrong-path word is discarded (flush_id=1).
- On that same cycle: fetch_pc_load=1, fetch_pc_target=`pend_pc`, and `pend_v` clears on the next edge.
- A second redirect while `pend_v` is set overwrites `pend_pc` (youngest EX redirect wins).

Other rules:
- x0 never produces a load-use stall.
- Simultaneous imem_resp and dmem stall: the fetched word is held in IF/ID by stall_id, and `pend_v` handling is deferred until the D-stall drops.

## Timing
- All stall, flush, bubble and fetch_pc outputs are combinational, with zero-cycle latency from inputs, `st` and `pend_v`.
- `st`, `pend_v`, `pend_pc` and the counters update on posedge clk.
- A load-use hazard costs exactly 1 bubble cycle. A redirect costs 2 squashed instructions (ID and the IF word).
- Reset (rst=0, asynchronous): `st`=RUN, `pend_v`=0, `pend_pc`=0, counters=0.
  - All outputs are forced to 0 while rst=0, including fetch_pc_target=0.
  - Reset mid-miss drops the pending redirect.

## Configuration
`HAZARD_CTRL_PERF_EN` compiles the performance counters in or out.
- **Defined:** four 32-bit saturating counters, each incrementing once per cycle of its event:
  - perf_loaduse: load-use bubble
  - perf_istall: I-stall, including a pending-redirect stall
  - perf_dstall: D-stall
  - perf_flush: redirect accepted
- **Undefined:** the counters are not instantiated and the perf_* ports are tied to 0. Port list is unchanged.

## Structure
- `hazard_state_t` (RUN/IWAIT/DWAIT/IDWAIT) goes in `rv32i_types`.
- Sub-module `sat_counter32` (enable, async active-low reset, saturates at 32'hFFFF_FFFF), instantiated 4× under the macro.

## Test plan
- **Load-use:** `lw x5` in EX, `add x6,x5,x1` in ID → one cycle with stall_if=stall_id=bubble_ex=1, then the add advances. With EX_rd=0, no stall.
- **D-stall:** dmem_access=1 and dmem_resp=0 for 3 cycles → stall_if/id/ex/mem and bubble_wb=1 for 3 cycles. A simultaneous EX_redirect is not acted on until release.
- **Redirect with IF idle:** EX_redirect=1, EX_target_pc=0x60000100 → same cycle fetch_pc_load=1, target 0x60000100, flush_id=bubble_ex=1.
- **Redirect during I-miss:** EX_redirect with imem_read=1, resp=0 → pend_v=1. Resp arrives 4 cycles later → flush_id=1, fetch_pc_load=1, target 0x60000100, pend_v=0 next cycle.
- **Async reset:** assert rst=0 mid-IDWAIT with pend_v=1 → all outputs 0 immediately. After release, state is RUN and perf_* read 0.
- **Perf (macro defined):** 2 load-use, 5 D-stall, 3 redirects → perf_loaduse=2, perf_dstall=5, perf_flush=3. Preload 32'hFFFF_FFFF, one more event → counter holds 32'hFFFF_FFFF.
